// File: rtl/pcm_capture.sv
// Audio capture path: rate-decimates a 16-bit stereo sample stream and writes
// each admitted frame as 8/16-bit mono/stereo bytes into the capture FIFO.
module pcm_capture #(
  parameter int FREE_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_sample,
  input  logic [7:0]        sample_rate,
  input  logic              capture_enable,
  input  logic              mode_stereo,
  input  logic              mode_16bit,
  input  logic [15:0]       left_in,
  input  logic [15:0]       right_in,
  input  logic              overflow_clear,
  input  logic [FREE_W-1:0] fifo_free,
  output logic [7:0]        fifo_wrdata,
  output logic              fifo_write,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_L_LO = 3'd1,
    WR_L_HI = 3'd2,
    WR_R_LO = 3'd3,
    WR_R_HI = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  rate7;
  logic        evt_q;
  logic [15:0] ch0_q, ch0_d;
  logic [15:0] r_q;
  logic        stereo_q, b16_q;
  logic        ovf_q, ovf_d;
  logic [7:0]  last_q;
  logic [7:0]  byte_sel;
  logic        wr;
  logic [2:0]  n_bytes;
  logic        fits, idle, start, drop;
  logic [15:0] mono;

  // Same accumulator as playback, so both sides decimate on identical strobes.
  assign rate7 = (sample_rate > 8'd128) ? 8'd128 : sample_rate;
  assign acc_d = acc_q + rate7;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 8'd0;
      evt_q <= 1'b0;
    end else begin
      evt_q <= next_sample & (acc_q[7] ^ acc_d[7]);
      if (next_sample) acc_q <= acc_d;
    end
  end

  assign n_bytes = mode_16bit ? (mode_stereo ? 3'd4 : 3'd2)
                              : (mode_stereo ? 3'd2 : 3'd1);
  assign fits    = fifo_free >= FREE_W'(n_bytes);
  assign idle    = (state_q == IDLE);
  assign start   = evt_q & idle & capture_enable & fits;
  assign drop    = evt_q & (~idle | (capture_enable & ~fits));

  // Floor average of the two channels: 17-bit sum, arithmetic shift right.
  assign mono  = 16'(($signed({left_in[15], left_in}) +
                      $signed({right_in[15], right_in})) >>> 1);
  assign ch0_d = mode_stereo ? left_in : mono;
  assign ovf_d = overflow_clear ? 1'b0 : (drop ? 1'b1 : ovf_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch0_q    <= 16'd0;
      r_q      <= 16'd0;
      stereo_q <= 1'b0;
      b16_q    <= 1'b0;
      ovf_q    <= 1'b0;
      last_q   <= 8'd0;
    end else begin
      ovf_q <= ovf_d;
      if (start) begin
        ch0_q    <= ch0_d;
        r_q      <= right_in;
        stereo_q <= mode_stereo;
        b16_q    <= mode_16bit;
      end
      if (wr) last_q <= byte_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = mode_16bit ? WR_L_LO : WR_L_HI;
      WR_L_LO: state_d = WR_L_HI;
      WR_L_HI: state_d = stereo_q ? (b16_q ? WR_R_LO : WR_R_HI) : IDLE;
      WR_R_LO: state_d = WR_R_HI;
      WR_R_HI: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr       = 1'b1;
    byte_sel = last_q;
    case (state_q)
      WR_L_LO: byte_sel = ch0_q[7:0];
      WR_L_HI: byte_sel = ch0_q[15:8];
      WR_R_LO: byte_sel = r_q[7:0];
      WR_R_HI: byte_sel = r_q[15:8];
      default: wr = 1'b0;
    endcase
  end

  assign fifo_write  = wr;
  assign fifo_wrdata = byte_sel;
  assign busy        = wr;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pcm_capture.sv
// Self-checking bench for pcm_capture: directed frame table, multi-cycle
// corner sequences, and a randomized run against a transaction-level model.
module tb_pcm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        next_sample = 1'b0;
  logic [7:0]  sample_rate = 8'd128;
  logic        capture_enable = 1'b1;
  logic        mode_stereo = 1'b0;
  logic        mode_16bit = 1'b0;
  logic [15:0] left_in = 16'd0;
  logic [15:0] right_in = 16'd0;
  logic        overflow_clear = 1'b0;
  logic [11:0] fifo_free = 12'd100;
  logic [7:0]  fifo_wrdata;
  logic        fifo_write;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  pcm_capture #(.FREE_W(12)) dut (
    .clk(clk), .rst(rst), .next_sample(next_sample), .sample_rate(sample_rate),
    .capture_enable(capture_enable), .mode_stereo(mode_stereo),
    .mode_16bit(mode_16bit), .left_in(left_in), .right_in(right_in),
    .overflow_clear(overflow_clear), .fifo_free(fifo_free),
    .fifo_wrdata(fifo_wrdata), .fifo_write(fifo_write), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_sample = 1'b0;
    overflow_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_ovf();
    overflow_clear = 1'b1;
    @(posedge clk); #1;
    overflow_clear = 1'b0;
  endtask

  // One next_sample strobe, then watch cyc cycles; offsets are relative to the strobe cycle.
  task automatic collect(input int cyc, output int n, output logic [31:0] col,
                         output int first, output int last, output int bcnt);
    n = 0; col = 32'd0; first = -1; last = -1; bcnt = 0;
    next_sample = 1'b1;
    @(posedge clk); #1;
    next_sample = 1'b0;
    for (int k = 1; k <= cyc; k++) begin
      if (busy) bcnt++;
      if (fifo_write) begin
        col = {col[23:0], fifo_wrdata};
        if (first < 0) first = k;
        last = k;
        n++;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        st;
    logic        b16;
    logic [15:0] l;
    logic [15:0] r;
    logic [11:0] free;
    int          n;
    logic [31:0] bytes;
    logic        ovf;
  } vec_t;

  vec_t vt[9];

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } exp_t;

  exp_t       q[$];
  int         acc_m;
  int         busy_end;
  bit         evt_pend;
  bit         ovf_m;
  logic [7:0] last_m;

  task automatic push_word(input logic [15:0] w, input bit b16, input int base, inout int k);
    if (b16) begin
      q.push_back('{base + k, w[7:0]});
      k++;
    end
    q.push_back('{base + k, w[15:8]});
    k++;
  endtask

  initial begin
    int n, first, last, bcnt, total;
    logic [31:0] col;
    logic [3:0] fired;
    int rates[8];

    vt[0] = '{1'b1, 1'b1, 16'h1234, 16'hABCD, 12'd100, 4, 32'h3412CDAB, 1'b0};
    vt[1] = '{1'b0, 1'b1, 16'h8000, 16'hFFFF, 12'd100, 2, 32'h0000FFBF, 1'b0};
    vt[2] = '{1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 12'd100, 2, 32'h0000FF7F, 1'b0};
    vt[3] = '{1'b0, 1'b0, 16'h4000, 16'h2000, 12'd100, 1, 32'h00000030, 1'b0};
    vt[4] = '{1'b1, 1'b0, 16'h1234, 16'hABCD, 12'd100, 2, 32'h000012AB, 1'b0};
    vt[5] = '{1'b1, 1'b1, 16'h1234, 16'hABCD, 12'd3,   0, 32'h00000000, 1'b1};
    vt[6] = '{1'b1, 1'b1, 16'h5678, 16'h9ABC, 12'd4,   4, 32'h78563412 ^ 32'h2E2E88AE, 1'b0};
    vt[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 12'd0,   0, 32'h00000000, 1'b1};
    vt[8] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 12'd1,   1, 32'h00000000, 1'b0};
    vt[6].bytes = 32'h7856BC9A;

    do_reset();
    chk("reset_write", {31'd0, fifo_write}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);
    chk("reset_data", {24'd0, fifo_wrdata}, 32'd0);

    sample_rate = 8'd128;
    capture_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      clear_ovf();
      mode_stereo = vt[i].st;
      mode_16bit  = vt[i].b16;
      left_in     = vt[i].l;
      right_in    = vt[i].r;
      fifo_free   = vt[i].free;
      collect(8, n, col, first, last, bcnt);
      chk($sformatf("vec%0d_count", i), n, vt[i].n);
      chk($sformatf("vec%0d_bytes", i), col, vt[i].bytes);
      chk($sformatf("vec%0d_busy", i), bcnt, vt[i].n);
      chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vt[i].ovf});
      if (vt[i].n > 0) begin
        chk($sformatf("vec%0d_latency", i), first, 2);
        chk($sformatf("vec%0d_contig", i), last - first + 1, vt[i].n);
      end
    end

    // rate 64: of four strobes from acc=0, only the 2nd and 4th capture
    do_reset();
    sample_rate = 8'd64; mode_stereo = 1'b0; mode_16bit = 1'b0;
    left_in = 16'h4000; right_in = 16'h2000; fifo_free = 12'd100;
    total = 0; fired = 4'd0;
    for (int s = 0; s < 4; s++) begin
      collect(5, n, col, first, last, bcnt);
      total += n;
      if (n > 0) begin
        fired[s] = 1'b1;
        chk("rate64_byte", col, 32'h30);
      end
    end
    chk("rate64_total", total, 2);
    chk("rate64_pattern", {28'd0, fired}, 32'hA);

    // rate 200 clamps to 128: every strobe captures
    do_reset();
    sample_rate = 8'd200; mode_stereo = 1'b1; mode_16bit = 1'b1;
    left_in = 16'h1234; right_in = 16'hABCD;
    for (int s = 0; s < 3; s++) begin
      collect(7, n, col, first, last, bcnt);
      chk("rate200_count", n, 4);
      chk("rate200_bytes", col, 32'h3412CDAB);
    end

    // rate 0 never fires
    sample_rate = 8'd0;
    total = 0;
    next_sample = 1'b1;
    for (int s = 0; s < 1000; s++) begin
      @(posedge clk); #1;
      if (fifo_write) total++;
    end
    next_sample = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (fifo_write) total++;
    end
    chk("rate0_writes", total, 0);
    chk("rate0_ovf", {31'd0, overflow}, 32'd0);

    // overflow_clear in the drop cycle wins
    sample_rate = 8'd128; fifo_free = 12'd3;
    next_sample = 1'b1;
    @(posedge clk); #1;
    next_sample = 1'b0; overflow_clear = 1'b1;
    @(posedge clk); #1;
    overflow_clear = 1'b0;
    chk("clr_wins_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_wins_nowrite", {31'd0, fifo_write}, 32'd0);

    // reset in WR_L_HI abandons the frame
    fifo_free = 12'd0;
    collect(6, n, col, first, last, bcnt);
    chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    fifo_free = 12'd100;
    next_sample = 1'b1;
    @(posedge clk); #1;
    next_sample = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_lhi", {23'd0, fifo_write, fifo_wrdata}, 32'h112);
    rst = 1'b1;
    #1;
    chk("rst_write", {31'd0, fifo_write}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    collect(8, n, col, first, last, bcnt);
    chk("post_rst_count", n, 4);
    chk("post_rst_bytes", col, 32'h3412CDAB);
    chk("post_rst_latency", first, 2);

    // randomized run against the frame-level model
    rates = '{0, 1, 37, 64, 100, 128, 129, 255};
    do_reset();
    acc_m = 0; busy_end = -1; evt_pend = 1'b0; ovf_m = 1'b0; last_m = 8'd0;
    q.delete();
    for (int c = 0; c < 4000; c++) begin
      bit exp_wr, drop;
      int r7, nb, k, s;
      logic [15:0] ch0;
      @(posedge clk); #1;
      exp_wr = (q.size() > 0) && (q[0].cyc == c);
      if (exp_wr) begin
        last_m = q[0].b;
        void'(q.pop_front());
      end
      chk("rnd_write", {31'd0, fifo_write}, {31'd0, exp_wr});
      chk("rnd_busy", {31'd0, busy}, {31'd0, exp_wr});
      chk("rnd_data", {24'd0, fifo_wrdata}, {24'd0, last_m});
      chk("rnd_ovf", {31'd0, overflow}, {31'd0, ovf_m});

      if (c % 400 == 0) sample_rate = 8'(rates[$urandom_range(0, 7)]);
      next_sample    = 1'($urandom_range(0, 1));
      capture_enable = ($urandom_range(0, 9) < 8);
      mode_stereo    = 1'($urandom_range(0, 1));
      mode_16bit     = 1'($urandom_range(0, 1));
      left_in        = 16'($urandom);
      right_in       = 16'($urandom);
      fifo_free      = 12'($urandom_range(0, 6));
      overflow_clear = ($urandom_range(0, 19) == 0);

      drop = 1'b0;
      if (evt_pend) begin
        if (c <= busy_end) drop = 1'b1;
        else if (capture_enable) begin
          nb = (mode_16bit ? 2 : 1) * (mode_stereo ? 2 : 1);
          if (int'(fifo_free) >= nb) begin
            s = $signed(left_in) + $signed(right_in);
            s = s >>> 1;
            ch0 = mode_stereo ? left_in : 16'(s);
            k = 0;
            push_word(ch0, mode_16bit, c + 1, k);
            if (mode_stereo) push_word(right_in, mode_16bit, c + 1, k);
            busy_end = c + nb;
          end else drop = 1'b1;
        end
      end
      if (overflow_clear) ovf_m = 1'b0;
      else if (drop) ovf_m = 1'b1;

      evt_pend = 1'b0;
      if (next_sample) begin
        r7 = (int'(sample_rate) > 128) ? 128 : int'(sample_rate);
        evt_pend = ((acc_m + r7) / 128) != (acc_m / 128);
        acc_m = (acc_m + r7) % 256;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, expected $finish");
    $fatal(1);
  end

endmodule
